// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS
//   core. Owns the PC, presents it to instruction memory and captures the
//   returned word, together with its PC+4, into the IF/ID register.
//
//   Parameters
//     RESET_PC       PC value loaded on reset
//     NOP_INS        word placed in IF/ID for a bubble or flush
//
//   Ports
//     clk            core clock, all state updates on the rising edge
//     rst_n          asynchronous active-low reset
//     stall          load-use hold from hazard control (PC and IF/ID hold)
//     branch_taken   redirect from EX: load branch_target, flush IF/ID
//     branch_target  redirect address, low two bits ignored
//     imem_addr      word-aligned instruction address (combinational from pc)
//     imem_data      instruction word returned for imem_addr
//     imem_valid     imem_data is valid this cycle (0 = memory wait)
//     pc             current PC register
//     if_id_ins      IF/ID instruction
//     if_id_pc4      IF/ID PC+4 of the latched instruction
//     if_id_valid    IF/ID holds a real instruction (not a bubble)
//     stall_count    number of stalled edges, saturating
//
//   Configuration
//     FETCH_STALL_CNT_EN  when defined, stall_count counts edges with
//                         stall=1 and branch_taken=0, saturating at all ones
//                         and cleared only by reset. When undefined there
//                         are no counter flops and stall_count reads zero.
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INS  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        imem_valid,
    output logic [31:0] pc,
    output logic [31:0] if_id_ins,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [31:0] stall_count
);

    logic [31:0] pc_plus4;
    logic        unused_target_bits;

    // Sequential PC arithmetic wraps naturally modulo 2^32.
    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = {pc[31:2], 2'b00};

    // Redirect addresses are always word aligned; the dropped bits are kept
    // only so the unused-input check stays quiet.
    assign unused_target_bits = ^branch_target[1:0];

    // PC and IF/ID register. A redirect wins over a stall because the
    // stalled instruction is on the wrong path; a stall wins over a memory
    // wait so the held instruction is not replaced by a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            if_id_ins   <= NOP_INS;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
        end else if (branch_taken) begin
            pc          <= {branch_target[31:2], 2'b00};
            if_id_ins   <= NOP_INS;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            if (imem_valid) begin
                pc          <= pc_plus4;
                if_id_ins   <= imem_data;
                if_id_pc4   <= pc_plus4;
                if_id_valid <= 1'b1;
            end else begin
                if_id_ins   <= NOP_INS;
                if_id_pc4   <= 32'd0;
                if_id_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Counts only genuine stalls: an edge where a redirect overrides the
    // stall does not hold the pipeline and is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
        end else if (stall && !branch_taken && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Self-checking bench for fetch_stage. Two instances share the control
//   inputs: dut0 uses the default reset PC, dut1 resets to 32'hFFFF_FFFC to
//   exercise PC wrap-around. A behavioural model of each instance is kept
//   in the bench and compared against the outputs on every falling edge;
//   directed sequences add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFFC;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_valid;

    logic [31:0] mem [256];

    logic [31:0] addr0, data0, pc0, ins0, pc40, cnt0;
    logic        valid0;
    logic [31:0] addr1, data1, pc1, ins1, pc41, cnt1;
    logic        valid1;

    int n_cmp;
    int n_bad;

    // Instruction memory is a simple combinational lookup on the word index.
    assign data0 = mem[addr0[9:2]];
    assign data1 = mem[addr1[9:2]];

    fetch_stage dut0 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_addr(addr0), .imem_data(data0),
        .imem_valid(imem_valid), .pc(pc0), .if_id_ins(ins0), .if_id_pc4(pc40),
        .if_id_valid(valid0), .stall_count(cnt0)
    );

    fetch_stage #(.RESET_PC(WRAP_PC)) dut1 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_addr(addr1), .imem_data(data1),
        .imem_valid(imem_valid), .pc(pc1), .if_id_ins(ins1), .if_id_pc4(pc41),
        .if_id_valid(valid1), .stall_count(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: one entry per instance.
    logic [31:0] m_pc    [2];
    logic [31:0] m_ins   [2];
    logic [31:0] m_pc4   [2];
    logic        m_valid [2];
    logic [31:0] m_cnt   [2];

    function automatic logic [31:0] resetPc(input int k);
        return (k == 0) ? 32'h0000_0000 : WRAP_PC;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_pc[k]    <= resetPc(k);
                m_ins[k]   <= NOP;
                m_pc4[k]   <= 32'd0;
                m_valid[k] <= 1'b0;
                m_cnt[k]   <= 32'd0;
            end else begin
                if (branch_taken) begin
                    m_pc[k]    <= branch_target & 32'hFFFF_FFFC;
                    m_ins[k]   <= NOP;
                    m_pc4[k]   <= 32'd0;
                    m_valid[k] <= 1'b0;
                end else if (stall) begin
                    m_pc[k] <= m_pc[k];
                end else if (!imem_valid) begin
                    m_ins[k]   <= NOP;
                    m_pc4[k]   <= 32'd0;
                    m_valid[k] <= 1'b0;
                end else begin
                    m_ins[k]   <= mem[m_pc[k][9:2]];
                    m_pc4[k]   <= m_pc[k] + 32'd4;
                    m_pc[k]    <= m_pc[k] + 32'd4;
                    m_valid[k] <= 1'b1;
                end
`ifdef FETCH_STALL_CNT_EN
                if (stall && !branch_taken && m_cnt[k] != 32'hFFFF_FFFF)
                    m_cnt[k] <= m_cnt[k] + 32'd1;
`endif
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareDut(input int k, input logic [31:0] p, input logic [31:0] a,
                              input logic [31:0] ins, input logic [31:0] p4,
                              input logic v, input logic [31:0] c);
        checkOutput($sformatf("dut%0d.pc", k), p, m_pc[k]);
        checkOutput($sformatf("dut%0d.imem_addr", k), a, m_pc[k] & 32'hFFFF_FFFC);
        checkOutput($sformatf("dut%0d.if_id_ins", k), ins, m_ins[k]);
        checkOutput($sformatf("dut%0d.if_id_pc4", k), p4, m_pc4[k]);
        checkOutput($sformatf("dut%0d.if_id_valid", k), {31'd0, v}, {31'd0, m_valid[k]});
        checkOutput($sformatf("dut%0d.stall_count", k), c, m_cnt[k]);
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        compareDut(0, pc0, addr0, ins0, pc40, valid0, cnt0);
        compareDut(1, pc1, addr1, ins1, pc41, valid1, cnt1);
    end

    task automatic applyStimulus(input logic s, input logic b,
                                 input logic [31:0] t, input logic v);
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        imem_valid    = v;
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] expCount(input logic [31:0] n);
`ifdef FETCH_STALL_CNT_EN
        return n;
`else
        return 32'd0 & n;
`endif
    endfunction

    task automatic checkDut0(input string tag, input logic [31:0] p, input logic [31:0] ins,
                             input logic [31:0] p4, input logic v);
        checkOutput({tag, ".pc"}, pc0, p);
        checkOutput({tag, ".ins"}, ins0, ins);
        checkOutput({tag, ".pc4"}, pc40, p4);
        checkOutput({tag, ".valid"}, {31'd0, valid0}, {31'd0, v});
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h2008_0005;

        rst_n = 1'b0;
        stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0; imem_valid = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checkDut0("reset", 32'h0, NOP, 32'h0, 1'b0);
        checkOutput("reset.cnt", cnt0, 32'd0);
        checkOutput("reset.dut1.pc", pc1, 32'hFFFF_FFFC);
        rst_n = 1'b1;

        // First fetch after release; dut1 wraps from FFFF_FFFC to 0.
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkDut0("fetch1", 32'd4, 32'h2008_0005, 32'd4, 1'b1);
        checkOutput("wrap.pc", pc1, 32'h0000_0000);
        checkOutput("wrap.pc4", pc41, 32'h0000_0000);
        checkOutput("wrap.ins", ins1, mem[255]);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkDut0("fetch2", 32'd8, mem[1], 32'd8, 1'b1);

        // Three-cycle stall at pc=8, then release.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
            checkDut0("stall", 32'd8, mem[1], 32'd8, 1'b1);
            checkOutput("stall.cnt", cnt0, expCount(32'(i + 1)));
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkDut0("release", 32'd12, mem[2], 32'd12, 1'b1);
        checkOutput("release.cnt", cnt0, expCount(32'd3));
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);

        // Memory wait at pc=16 for two cycles.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
            checkDut0("wait", 32'd16, NOP, 32'd0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkDut0("unwait", 32'd20, mem[4], 32'd20, 1'b1);

        // Redirect overriding a simultaneous stall.
        applyStimulus(1'b1, 1'b1, 32'h0000_0043, 1'b1);
        checkDut0("branch", 32'h40, NOP, 32'd0, 1'b0);
        checkOutput("branch.cnt", cnt0, expCount(32'd3));
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkDut0("target", 32'h44, mem[16], 32'h44, 1'b1);

        // Asynchronous reset pulsed between edges during a stall.
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        checkDut0("areset", 32'h0, NOP, 32'd0, 1'b0);
        checkOutput("areset.cnt", cnt0, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        rst_n = 1'b1;

        // Randomized traffic, checked continuously against the model.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom % 4) == 0, ($urandom % 10) == 0,
                          $urandom, ($urandom % 5) != 0);
            if (($urandom % 97) == 0) begin
                #1 rst_n = 1'b0;
                #1;
                checkDut0("rnd_reset", 32'h0, NOP, 32'd0, 1'b0);
                rst_n = 1'b1;
            end
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
